// File: rtl/memory_pkg.sv
// Shared types and sizing helpers for the tracked memory and its clear sweeper.
package memory_pkg;

    typedef enum logic {IDLE, SWEEP} clear_state_e;

    function automatic int lane_count(input int w);
        return w / 8;
    endfunction

    function automatic int addr_width(input int d);
        return $clog2(d);
    endfunction

    function automatic int count_width(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/mem_clear_fsm.sv
// Clear sweeper: walks every word once after a clear pulse, zeroing it.
module mem_clear_fsm
    import memory_pkg::*;
#(
    parameter int depth = 256,
    parameter int aw    = addr_width(depth)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    output logic          busy,
    output logic [aw-1:0] sweep_addr,
    output logic          sweep_we
);

    localparam logic [aw-1:0] last_addr = aw'(depth - 1);

    clear_state_e  state, next_state;
    logic [aw-1:0] ptr, ptr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= next_state;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        next_state = state;
        ptr_next   = ptr;
        busy       = 1'b0;
        sweep_we   = 1'b0;
        case (state)
            IDLE: begin
                ptr_next = '0;
                if (clear) next_state = SWEEP;
            end
            SWEEP: begin
                busy     = 1'b1;
                sweep_we = 1'b1;
                ptr_next = ptr + 1'b1;
                if (ptr == last_addr) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign sweep_addr = ptr;

endmodule

// File: rtl/tracked_memory.sv
// Single-port byte-enabled memory with per-word occupancy tracking,
// registered read handshake and a self-timed clear sweep.
module tracked_memory
    import memory_pkg::*;
#(
    parameter int width = 32,
    parameter int depth = 256,
    parameter int aw    = addr_width(depth)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [aw-1:0]            address,
    input  logic [width-1:0]         datain,
    input  logic [lane_count(width)-1:0] byte_en,
    input  logic                     write_en,
    input  logic                     read_en,
    input  logic                     clear,
    output logic [width-1:0]         data_out,
    output logic                     read_ack,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic [aw:0]              count,
    output logic                     busy
);

    localparam int            lanes      = lane_count(width);
    localparam logic [aw:0]   full_count = (aw+1)'(depth);

    logic [width-1:0] mem [depth];
    logic [depth-1:0] valid;
    logic [aw-1:0]    sweep_addr;
    logic             sweep_we;
    logic             clear_go, wr_go, rd_go;

    mem_clear_fsm #(.depth(depth), .aw(aw)) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .busy       (busy),
        .sweep_addr (sweep_addr),
        .sweep_we   (sweep_we)
    );

    // A clear pulse in IDLE takes priority and drops any access in the same cycle.
    always_comb begin
        clear_go = clear && !busy;
        wr_go    = write_en && !busy && !clear && (|byte_en);
        rd_go    = read_en && !busy && !clear;
    end

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= '0;
        end else if (wr_go) begin
            for (int unsigned i = 0; i < lanes; i++) begin
                if (byte_en[i]) mem[address][8*i +: 8] <= datain[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (sweep_we) begin
            valid[sweep_addr] <= 1'b0;
        end else if (wr_go) begin
            valid[address] <= 1'b1;
        end
    end

    // Count drops to zero at sweep start; valid bits are cleared word by word
    // behind it, and no write can land until the sweep ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear_go) begin
            count <= '0;
        end else if (wr_go && !valid[address]) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            read_ack   <= 1'b0;
        end else begin
            read_ack <= rd_go;
            if (rd_go) begin
                data_out   <= valid[address] ? mem[address] : '0;
                data_valid <= valid[address];
            end
        end
    end

    always_comb begin
        full  = (count == full_count);
        empty = (count == '0);
    end

endmodule

// File: tb/tb_tracked_memory.sv
// Self-checking bench for tracked_memory (width=32, depth=256).
module tb_tracked_memory;

    localparam int W = 32;
    localparam int D = 256;
    localparam int A = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [A-1:0]  address = '0;
    logic [W-1:0]  datain = '0;
    logic [3:0]    byte_en = '0;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic          clear = 1'b0;
    logic [W-1:0]  data_out;
    logic          read_ack;
    logic          data_valid;
    logic          full;
    logic          empty;
    logic [A:0]    count;
    logic          busy;

    tracked_memory #(.width(W), .depth(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .datain     (datain),
        .byte_en    (byte_en),
        .write_en   (write_en),
        .read_en    (read_en),
        .clear      (clear),
        .data_out   (data_out),
        .read_ack   (read_ack),
        .data_valid (data_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: contents, occupancy, outstanding sweep cycles, read register.
    logic [W-1:0] m_mem [D];
    bit           m_val [D];
    int           m_sweep_left = 0;
    logic [W-1:0] m_dout = '0;
    bit           m_ack  = 0;
    bit           m_dv   = 0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < D; i++) n += m_val[i];
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_val[i] = 0;
        m_sweep_left = 0;
        m_dout = '0;
        m_ack  = 0;
        m_dv   = 0;
    endtask

    // One clock edge as seen by a user of the memory.
    task automatic model_edge(input bit we, input bit re, input bit clr,
                              input int adr, input logic [W-1:0] din, input logic [3:0] be);
        m_ack = 0;
        if (m_sweep_left > 0) begin
            m_sweep_left--;
        end else if (clr) begin
            m_sweep_left = D;
            for (int i = 0; i < D; i++) begin
                m_val[i] = 0;
                m_mem[i] = '0;
            end
        end else begin
            if (re) begin
                m_ack  = 1;
                m_dv   = m_val[adr];
                m_dout = m_val[adr] ? m_mem[adr] : '0;
            end
            if (we && be != 4'b0) begin
                for (int l = 0; l < 4; l++)
                    if (be[l]) m_mem[adr][8*l +: 8] = din[8*l +: 8];
                m_val[adr] = 1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int c = m_count();
        chk({tag, " read_ack"},   64'(read_ack),   64'(m_ack));
        chk({tag, " data_out"},   64'(data_out),   64'(m_dout));
        chk({tag, " data_valid"}, 64'(data_valid), 64'(m_dv));
        chk({tag, " count"},      64'(count),      64'(c));
        chk({tag, " full"},       64'(full),       64'(c == D));
        chk({tag, " empty"},      64'(empty),      64'(c == 0));
        chk({tag, " busy"},       64'(busy),       64'(m_sweep_left > 0));
    endtask

    task automatic cyc(input bit we, input bit re, input bit clr, input int adr,
                       input logic [W-1:0] din, input logic [3:0] be);
        write_en = we;
        read_en  = re;
        clear    = clr;
        address  = A'(adr);
        datain   = din;
        byte_en  = be;
        @(posedge clk);
        #1;
        model_edge(we, re, clr, adr, din, be);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, '0, '0);
    endtask

    typedef struct {
        bit           we;
        bit           re;
        int           adr;
        logic [W-1:0] din;
        logic [3:0]   be;
        logic [W-1:0] exp_dout;
        bit           exp_ack;
        bit           exp_dv;
        int           exp_count;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int busy_cycles;
        int n_seen;

        vecs[0] = '{1, 0, 3, 32'hAABBCCDD, 4'b1111, 32'h0,        0, 0, 1};
        vecs[1] = '{1, 0, 3, 32'h11223344, 4'b0101, 32'h0,        0, 0, 1};
        vecs[2] = '{0, 1, 3, 32'h0,        4'b0000, 32'hAA22CC44, 1, 1, 1};
        vecs[3] = '{1, 0, 3, 32'hFFFFFFFF, 4'b0000, 32'hAA22CC44, 0, 1, 1};
        vecs[4] = '{0, 1, 3, 32'h0,        4'b0000, 32'hAA22CC44, 1, 1, 1};
        vecs[5] = '{1, 0, 7, 32'h00000001, 4'b1111, 32'hAA22CC44, 0, 1, 2};
        vecs[6] = '{1, 1, 7, 32'h00000002, 4'b1111, 32'h00000001, 1, 1, 2};
        vecs[7] = '{0, 1, 7, 32'h0,        4'b0000, 32'h00000002, 1, 1, 2};
        vecs[8] = '{0, 1, 9, 32'h0,        4'b0000, 32'h0,        1, 0, 2};

        // Reset asserted mid-cycle takes effect without a clock edge.
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(0, 1, 0, 5, '0, '0);
        check_all("read_after_reset");
        chk("reset_read_ack", 64'(read_ack), 64'd1);

        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].we, vecs[i].re, 0, vecs[i].adr, vecs[i].din, vecs[i].be);
            chk($sformatf("vec%0d data_out", i),   64'(data_out),   64'(vecs[i].exp_dout));
            chk($sformatf("vec%0d read_ack", i),   64'(read_ack),   64'(vecs[i].exp_ack));
            chk($sformatf("vec%0d data_valid", i), 64'(data_valid), 64'(vecs[i].exp_dv));
            chk($sformatf("vec%0d count", i),      64'(count),      64'(vecs[i].exp_count));
        end
        idle();
        check_all("ack_drops");

        // Fill every address.
        for (int a = 0; a < D; a++) begin
            cyc(1, 0, 0, a, 32'(a) * 32'h01010101 ^ 32'h5A5A0000, 4'b1111);
            check_all("fill");
        end
        chk("fill_count", 64'(count), 64'd256);
        chk("fill_full",  64'(full),  64'd1);
        cyc(1, 0, 0, 0, 32'hDEADBEEF, 4'b1111);
        chk("rewrite_count", 64'(count), 64'd256);
        cyc(0, 1, 0, 0, '0, '0);
        check_all("rewrite_read");

        // Clear with a simultaneous access: clear wins.
        cyc(1, 1, 1, 12, 32'h12345678, 4'b1111);
        check_all("clear_start");
        chk("clear_count0", 64'(count), 64'd0);
        busy_cycles = busy ? 1 : 0;
        n_seen = 0;
        while (busy && n_seen < 1000) begin
            if (n_seen == 10) cyc(1, 1, 0, 20, 32'hCAFEF00D, 4'b1111);
            else if (n_seen == 11) cyc(0, 1, 0, 20, '0, '0);
            else idle();
            if (n_seen == 10 || n_seen == 11) chk("sweep_no_ack", 64'(read_ack), 64'd0);
            check_all("sweep");
            if (busy) busy_cycles++;
            n_seen++;
        end
        chk("sweep_length", 64'(busy_cycles), 64'd256);
        for (int a = 0; a < D; a += 37) begin
            cyc(0, 1, 0, a, '0, '0);
            check_all("post_clear_read");
            chk("post_clear_dv", 64'(data_valid), 64'd0);
        end

        // Randomized traffic against the model; memory is fully zeroed here.
        for (int n = 0; n < 3000; n++) begin
            bit we  = ($urandom_range(0, 1) == 1);
            bit re  = ($urandom_range(0, 1) == 1);
            bit clr = ($urandom_range(0, 499) == 0);
            int adr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, D-1))
                                                  : int'($urandom_range(0, 15));
            cyc(we, re, clr, adr, $urandom, 4'($urandom));
            check_all("random");
        end
        n_seen = 0;
        while (busy && n_seen < 400) begin
            idle();
            n_seen++;
        end
        chk("random_drain", 64'(busy), 64'd0);

        // Reset in the middle of a sweep.
        cyc(1, 0, 0, 40, 32'h0BADF00D, 4'b1111);
        cyc(0, 0, 1, 0, '0, '0);
        for (int i = 0; i < 100; i++) idle();
        check_all("pre_rst_sweep");
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid_sweep");
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1, 0, 0, 42, 32'h76543210, 4'b1111);
        check_all("after_rst_write");
        chk("after_rst_count", 64'(count), 64'd1);
        cyc(0, 1, 0, 42, '0, '0);
        check_all("after_rst_read");
        chk("after_rst_data", 64'(data_out), 64'h76543210);
        cyc(0, 1, 0, 40, '0, '0);
        check_all("after_rst_unwritten");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/tracked_memory.md
# tracked_memory

Parametrised single-port synchronous memory with per-byte write enables, per-word occupancy tracking and a hardware clear sweep. It is the next-generation storage block for the datapath: it replaces the plain width/depth memory with a `full` flag. It adds `empty`/`count` status, a registered read handshake with a word-valid indication, and a self-timed clear that zeroes contents without a reset.

## Interface
Parameters:
- `width`, 32: data word width in bits; must be a multiple of 8.
- `depth`, 256: number of words; must be a power of 2 and at least 2.
- `aw`, `$clog2(depth)`: derived address width; not overridden.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `address`, in, aw: word address shared by read and write.
- `datain`, in, width: write data.
- `byte_en`, in, width/8: byte lane write enables; bit i covers `datain[8i+7:8i]`.
- `write_en`, in, 1: write strobe.
- `read_en`, in, 1: read strobe.
- `clear`, in, 1: one-cycle pulse that starts the clear sweep.
- `data_out`, out, width: read data, registered.
- `read_ack`, out, 1: one-cycle pulse; `data_out`/`data_valid` are valid.
- `data_valid`, out, 1: the word read had been written since the last reset or clear.
- `full`, out, 1: `count == depth`.
- `empty`, out, 1: `count == 0`.
- `count`, out, aw+1: number of occupied words.
- `busy`, out, 1: clear sweep in progress.

## Operation
- **Reset values:** `data_out`=0, `read_ack`=0, `data_valid`=0, `count`=0, `full`=0, `empty`=1, `busy`=0, FSM=IDLE, all valid bits 0. Array contents are not reset.
- **Write** (`write_en` & not busy): lanes with `byte_en[i]`=1 are written and other lanes keep their value.
  - If any `byte_en` bit is set: valid[address] is set, and `count` increments only if valid[address] was 0.
  - `byte_en`=0 is a no-op: no data change, no valid change.
- **Read** (`read_en` & not busy): registered read.
  - `data_out` is mem[address] if valid[address]=1, else 0.
  - `data_valid` is valid[address]; `read_ack` pulses.
- **Same-cycle read and write to the same address:** read-first. The read returns the old data and the old valid bit; the write takes effect afterwards.
- **`count` arithmetic:** width aw+1, so `depth` is representable. It never wraps, because increments only happen on unoccupied words.
- **FSM states:**
  - IDLE --(`clear`)--> SWEEP.
  - SWEEP: an internal pointer steps 0..depth-1, writing 0 to the word and clearing its valid bit, one word per cycle.
  - After word depth-1: SWEEP --> IDLE.
- **In SWEEP:**
  - `busy`=1 and `count`=0.
  - `write_en`, `read_en` and `clear` are ignored: no `read_ack`, no state change.
- **`clear` with simultaneous `write_en`/`read_en` in IDLE:** clear wins and the access is dropped.
- **Reset asserted mid-sweep:** immediately returns to IDLE with `busy`=0, valid bits 0, `count`=0. Array contents are left partially swept, which is harmless because all valid bits are 0.

## Timing
- **Read latency:** 1 cycle. `read_en` sampled at edge N gives `read_ack`=1 and `data_out` valid after edge N, and `read_ack`=0 after edge N+1 unless `read_en` is held. Back-to-back reads sustain one per cycle.
- **Write:** visible to a read issued at the next edge.
- **`count`, `full`, `empty`:** update after the writing edge. `full` and `empty` are decoded from registered `count`.
- **Clear:** `clear` sampled at edge N.
  - `busy`=1 and `count`=0 after edge N.
  - The sweep runs for exactly `depth` cycles.
  - `busy`=0 after edge N+depth, and the first access is accepted at edge N+depth+1.
- `data_out` and `data_valid` hold their value between acks.

## Structure
- **Shared package `memory_pkg`:**
  - state enum {IDLE, SWEEP};
  - a byte-lane count function (width/8);
  - the address-width and count-width constants derived from `depth`.
- **Sub-module `mem_clear_fsm`:** the IDLE/SWEEP state, the sweep pointer and `busy`. It drives the sweep address and the zero-write enable into the top. The top level holds the array, the valid vector, `count` and the read register.

## Test plan
All scenarios use width=32, depth=256.
1. **Reset:** assert `rst` mid-cycle -> all outputs at reset values immediately; read addr 5 -> `read_ack`=1, `data_valid`=0, `data_out`=0.
2. **Byte-lane write:**
   - Write 0xAABBCCDD to addr 3 with `byte_en`=4'b1111, then 0x11223344 with `byte_en`=4'b0101.
   - Read addr 3 -> 0xAA22CC44, `data_valid`=1; `count`=1.
   - A further write with `byte_en`=0 -> data and `count` unchanged.
3. **Read-first collision:** addr 7 holds 0x1; read and write 0x2 to addr 7 in the same cycle -> `data_out`=0x1; next read -> 0x2. `count` unchanged on the rewrite.
4. **Fill:**
   - Write all 256 addresses -> `full`=1 and `count`=256 after the last write edge; `empty`=0 after the first write.
   - Rewriting addr 0 -> `count` stays 256.
5. **Clear sweep:**
   - Pulse `clear` on a full memory -> `busy`=1 for exactly 256 cycles and `count`=0 at once.
   - A write and a read issued during `busy` are ignored, with no `read_ack`.
   - After the sweep, reads of any address -> `data_valid`=0, `data_out`=0.
6. **Reset mid-sweep:** assert `rst` at sweep cycle 100 -> `busy`=0 immediately; after release, writes and reads are accepted normally and `count` restarts from 0.
